// File: rtl/operand_fetch.sv
// Dual-lane operand fetch: register-file read, writeback bypass, busy scoreboard
// interlocks and a single registered instruction pair toward execute.
module operand_fetch #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32
) (
  input  logic                    clock,
  input  logic                    reset,

  input  logic                    id_0_valid,
  output logic                    id_0_ready,
  input  logic [$clog2(NREG)-1:0] id_0_rs1,
  input  logic [$clog2(NREG)-1:0] id_0_rs2,
  input  logic [$clog2(NREG)-1:0] id_0_rd,
  input  logic                    id_0_rd_wen,

  input  logic                    id_1_valid,
  output logic                    id_1_ready,
  input  logic [$clog2(NREG)-1:0] id_1_rs1,
  input  logic [$clog2(NREG)-1:0] id_1_rs2,
  input  logic [$clog2(NREG)-1:0] id_1_rd,
  input  logic                    id_1_rd_wen,

  output logic [$clog2(NREG)-1:0] rf_0_raddr1,
  output logic [$clog2(NREG)-1:0] rf_0_raddr2,
  input  logic [XLEN-1:0]         rf_0_rdata1,
  input  logic [XLEN-1:0]         rf_0_rdata2,
  output logic [$clog2(NREG)-1:0] rf_1_raddr1,
  output logic [$clog2(NREG)-1:0] rf_1_raddr2,
  input  logic [XLEN-1:0]         rf_1_rdata1,
  input  logic [XLEN-1:0]         rf_1_rdata2,

  input  logic                    wb_0_wen,
  input  logic [$clog2(NREG)-1:0] wb_0_waddr,
  input  logic [XLEN-1:0]         wb_0_wdata,
  input  logic                    wb_1_wen,
  input  logic [$clog2(NREG)-1:0] wb_1_waddr,
  input  logic [XLEN-1:0]         wb_1_wdata,

  input  logic                    flush,

  output logic                    ex_0_valid,
  output logic                    ex_1_valid,
  input  logic                    ex_ready,
  output logic [XLEN-1:0]         ex_0_src1,
  output logic [XLEN-1:0]         ex_0_src2,
  output logic [XLEN-1:0]         ex_1_src1,
  output logic [XLEN-1:0]         ex_1_src2,
  output logic [$clog2(NREG)-1:0] ex_0_rd,
  output logic [$clog2(NREG)-1:0] ex_1_rd,
  output logic                    ex_0_rd_wen,
  output logic                    ex_1_rd_wen
);

  localparam int unsigned AW = $clog2(NREG);

  logic [NREG-1:0] busy_q, busy_d, busy_seen;
  logic            advance;
  logic            hazard0, hazard1, intra_dep;
  logic            accept0, accept1;
  logic [XLEN-1:0] res_0_src1, res_0_src2, res_1_src1, res_1_src2;

  // Youngest writeback (port 1) wins; x0 always reads as zero.
  function automatic logic [XLEN-1:0] resolve(
    input logic [AW-1:0]   rs,
    input logic [XLEN-1:0] rf_data,
    input logic            w0_en,
    input logic [AW-1:0]   w0_addr,
    input logic [XLEN-1:0] w0_data,
    input logic            w1_en,
    input logic [AW-1:0]   w1_addr,
    input logic [XLEN-1:0] w1_data
  );
    logic [XLEN-1:0] val;
    if (rs == '0) begin
      val = '0;
    end else if (w1_en && (w1_addr == rs)) begin
      val = w1_data;
    end else if (w0_en && (w0_addr == rs)) begin
      val = w0_data;
    end else begin
      val = rf_data;
    end
    return val;
  endfunction

  assign rf_0_raddr1 = id_0_rs1;
  assign rf_0_raddr2 = id_0_rs2;
  assign rf_1_raddr1 = id_1_rs1;
  assign rf_1_raddr2 = id_1_rs2;

  assign res_0_src1 = resolve(id_0_rs1, rf_0_rdata1, wb_0_wen, wb_0_waddr, wb_0_wdata,
                              wb_1_wen, wb_1_waddr, wb_1_wdata);
  assign res_0_src2 = resolve(id_0_rs2, rf_0_rdata2, wb_0_wen, wb_0_waddr, wb_0_wdata,
                              wb_1_wen, wb_1_waddr, wb_1_wdata);
  assign res_1_src1 = resolve(id_1_rs1, rf_1_rdata1, wb_0_wen, wb_0_waddr, wb_0_wdata,
                              wb_1_wen, wb_1_waddr, wb_1_wdata);
  assign res_1_src2 = resolve(id_1_rs2, rf_1_rdata2, wb_0_wen, wb_0_waddr, wb_0_wdata,
                              wb_1_wen, wb_1_waddr, wb_1_wdata);

  // A writeback landing this cycle already releases its register.
  always_comb begin
    busy_seen = busy_q;
    if (wb_0_wen) busy_seen[wb_0_waddr] = 1'b0;
    if (wb_1_wen) busy_seen[wb_1_waddr] = 1'b0;
    busy_seen[0] = 1'b0;
  end

  assign hazard0 = busy_seen[id_0_rs1] | busy_seen[id_0_rs2] |
                   (id_0_rd_wen & busy_seen[id_0_rd]);

  assign intra_dep = id_0_rd_wen & (id_0_rd != '0) &
                     ((id_1_rs1 == id_0_rd) | (id_1_rs2 == id_0_rd) | (id_1_rd == id_0_rd));

  assign hazard1 = busy_seen[id_1_rs1] | busy_seen[id_1_rs2] |
                   (id_1_rd_wen & busy_seen[id_1_rd]) | intra_dep;

  assign advance    = ~(ex_0_valid | ex_1_valid) | ex_ready;
  assign id_0_ready = advance & ~hazard0 & ~flush & ~reset;
  assign id_1_ready = id_0_ready & id_0_valid & ~hazard1;

  assign accept0 = id_0_valid & id_0_ready;
  assign accept1 = id_1_valid & id_1_ready;

  // Clears first, then sets, so an issue to a register written back this cycle stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_0_wen) busy_d[wb_0_waddr] = 1'b0;
    if (wb_1_wen) busy_d[wb_1_waddr] = 1'b0;
    if (flush) begin
      if (ex_0_valid && ex_0_rd_wen) busy_d[ex_0_rd] = 1'b0;
      if (ex_1_valid && ex_1_rd_wen) busy_d[ex_1_rd] = 1'b0;
    end
    if (accept0 && id_0_rd_wen) busy_d[id_0_rd] = 1'b1;
    if (accept1 && id_1_rd_wen) busy_d[id_1_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ex_0_valid  <= 1'b0;
      ex_1_valid  <= 1'b0;
      ex_0_src1   <= '0;
      ex_0_src2   <= '0;
      ex_1_src1   <= '0;
      ex_1_src2   <= '0;
      ex_0_rd     <= '0;
      ex_1_rd     <= '0;
      ex_0_rd_wen <= 1'b0;
      ex_1_rd_wen <= 1'b0;
    end else if (flush) begin
      ex_0_valid <= 1'b0;
      ex_1_valid <= 1'b0;
    end else if (advance) begin
      ex_0_valid <= accept0;
      ex_1_valid <= accept1;
      if (accept0) begin
        ex_0_src1   <= res_0_src1;
        ex_0_src2   <= res_0_src2;
        ex_0_rd     <= id_0_rd;
        ex_0_rd_wen <= id_0_rd_wen;
      end
      if (accept1) begin
        ex_1_src1   <= res_1_src1;
        ex_1_src2   <= res_1_src2;
        ex_1_rd     <= id_1_rd;
        ex_1_rd_wen <= id_1_rd_wen;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus randomized traffic
// against a register-level reference model.
module tb_operand_fetch;

  localparam int XLEN = 64;

  logic            clock = 1'b0;
  logic            reset;
  logic            id_0_valid, id_1_valid, id_0_ready, id_1_ready;
  logic [4:0]      id_0_rs1, id_0_rs2, id_0_rd, id_1_rs1, id_1_rs2, id_1_rd;
  logic            id_0_rd_wen, id_1_rd_wen;
  logic [4:0]      rf_0_raddr1, rf_0_raddr2, rf_1_raddr1, rf_1_raddr2;
  logic [XLEN-1:0] rf_0_rdata1, rf_0_rdata2, rf_1_rdata1, rf_1_rdata2;
  logic            wb_0_wen, wb_1_wen;
  logic [4:0]      wb_0_waddr, wb_1_waddr;
  logic [XLEN-1:0] wb_0_wdata, wb_1_wdata;
  logic            flush, ex_ready;
  logic            ex_0_valid, ex_1_valid, ex_0_rd_wen, ex_1_rd_wen;
  logic [XLEN-1:0] ex_0_src1, ex_0_src2, ex_1_src1, ex_1_src2;
  logic [4:0]      ex_0_rd, ex_1_rd;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit              m_busy [32];
  logic            m_v    [2];
  logic [XLEN-1:0] m_s1   [2];
  logic [XLEN-1:0] m_s2   [2];
  logic [4:0]      m_rd   [2];
  logic            m_wen  [2];

  always #5 clock = ~clock;

  operand_fetch #(.XLEN(64), .NREG(32)) dut (
    .clock(clock), .reset(reset),
    .id_0_valid(id_0_valid), .id_0_ready(id_0_ready), .id_0_rs1(id_0_rs1),
    .id_0_rs2(id_0_rs2), .id_0_rd(id_0_rd), .id_0_rd_wen(id_0_rd_wen),
    .id_1_valid(id_1_valid), .id_1_ready(id_1_ready), .id_1_rs1(id_1_rs1),
    .id_1_rs2(id_1_rs2), .id_1_rd(id_1_rd), .id_1_rd_wen(id_1_rd_wen),
    .rf_0_raddr1(rf_0_raddr1), .rf_0_raddr2(rf_0_raddr2),
    .rf_0_rdata1(rf_0_rdata1), .rf_0_rdata2(rf_0_rdata2),
    .rf_1_raddr1(rf_1_raddr1), .rf_1_raddr2(rf_1_raddr2),
    .rf_1_rdata1(rf_1_rdata1), .rf_1_rdata2(rf_1_rdata2),
    .wb_0_wen(wb_0_wen), .wb_0_waddr(wb_0_waddr), .wb_0_wdata(wb_0_wdata),
    .wb_1_wen(wb_1_wen), .wb_1_waddr(wb_1_waddr), .wb_1_wdata(wb_1_wdata),
    .flush(flush),
    .ex_0_valid(ex_0_valid), .ex_1_valid(ex_1_valid), .ex_ready(ex_ready),
    .ex_0_src1(ex_0_src1), .ex_0_src2(ex_0_src2), .ex_1_src1(ex_1_src1),
    .ex_1_src2(ex_1_src2), .ex_0_rd(ex_0_rd), .ex_1_rd(ex_1_rd),
    .ex_0_rd_wen(ex_0_rd_wen), .ex_1_rd_wen(ex_1_rd_wen)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_0_valid = 0; id_0_rs1 = 0; id_0_rs2 = 0; id_0_rd = 0; id_0_rd_wen = 0;
    id_1_valid = 0; id_1_rs1 = 0; id_1_rs2 = 0; id_1_rd = 0; id_1_rd_wen = 0;
    rf_0_rdata1 = 0; rf_0_rdata2 = 0; rf_1_rdata1 = 0; rf_1_rdata2 = 0;
    wb_0_wen = 0; wb_0_waddr = 0; wb_0_wdata = 0;
    wb_1_wen = 0; wb_1_waddr = 0; wb_1_wdata = 0;
    flush = 0; ex_ready = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    id_0_valid = 1; id_0_rs1 = 3; id_0_rs2 = 4;
    rf_0_rdata1 = 64'h11; rf_0_rdata2 = 64'h22;
    tick(); tick();
    tests++; if (ex_0_valid !== 1'b0 || ex_1_valid !== 1'b0) begin
      fails++; $display("FAIL reset_valid got %b%b exp 00", ex_0_valid, ex_1_valid); end
    tests++; if (id_0_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready got %b exp 0", id_0_ready); end
    tests++; if (ex_0_src1 !== 64'h0 || ex_0_rd !== 5'd0 || ex_0_rd_wen !== 1'b0) begin
      fails++; $display("FAIL reset_payload got %h/%0d/%b exp 0/0/0", ex_0_src1, ex_0_rd,
                        ex_0_rd_wen); end
    reset = 0;
    #1;
    tests++; if (id_0_ready !== 1'b1) begin
      fails++; $display("FAIL post_reset_ready got %b exp 1", id_0_ready); end
    tests++; if (rf_0_raddr1 !== 5'd3 || rf_0_raddr2 !== 5'd4) begin
      fails++; $display("FAIL raddr got %0d/%0d exp 3/4", rf_0_raddr1, rf_0_raddr2); end
    tick();
    tests++; if (ex_0_valid !== 1'b1 || ex_0_src1 !== 64'h11 || ex_0_src2 !== 64'h22) begin
      fails++; $display("FAIL post_reset_issue got v=%b %h %h exp v=1 11 22",
                        ex_0_valid, ex_0_src1, ex_0_src2); end
    idle_inputs();
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    id_0_valid = 1; id_0_rs1 = 5; id_0_rs2 = 0;
    rf_0_rdata1 = 64'hAA; rf_0_rdata2 = 64'h99;
    wb_0_wen = 1; wb_0_waddr = 5; wb_0_wdata = 64'h55;
    wb_1_wen = 1; wb_1_waddr = 5; wb_1_wdata = 64'h77;
    tick();
    tests++; if (ex_0_src1 !== 64'h77 || ex_0_src2 !== 64'h0) begin
      fails++; $display("FAIL bypass_both got %h/%h exp 77/0", ex_0_src1, ex_0_src2); end
    wb_1_wen = 0;
    tick();
    tests++; if (ex_0_src1 !== 64'h55) begin
      fails++; $display("FAIL bypass_wb0 got %h exp 55", ex_0_src1); end
    wb_0_wen = 0;
    tick();
    tests++; if (ex_0_src1 !== 64'hAA) begin
      fails++; $display("FAIL no_bypass got %h exp aa", ex_0_src1); end
    id_0_rs1 = 0; wb_0_wen = 1; wb_0_waddr = 0;
    tick();
    tests++; if (ex_0_src1 !== 64'h0) begin
      fails++; $display("FAIL x0_zero got %h exp 0", ex_0_src1); end
    idle_inputs();
    tick();
  endtask

  task automatic test_raw();
    idle_inputs();
    id_0_valid = 1; id_0_rd = 7; id_0_rd_wen = 1;
    tick();
    tests++; if (ex_0_valid !== 1'b1 || ex_0_rd !== 5'd7 || ex_0_rd_wen !== 1'b1) begin
      fails++; $display("FAIL raw_issue got v=%b rd=%0d exp v=1 rd=7", ex_0_valid, ex_0_rd); end
    id_0_rd = 0; id_0_rd_wen = 0; id_0_rs2 = 7; rf_0_rdata2 = 64'hDEAD;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_0_ready !== 1'b0) begin
        fails++; $display("FAIL raw_stall cycle %0d got %b exp 0", i, id_0_ready); end
      tick();
    end
    tests++; if (ex_0_valid !== 1'b0) begin
      fails++; $display("FAIL raw_bubble got %b exp 0", ex_0_valid); end
    wb_0_wen = 1; wb_0_waddr = 7; wb_0_wdata = 64'h1234;
    #1;
    tests++; if (id_0_ready !== 1'b1) begin
      fails++; $display("FAIL raw_release got %b exp 1", id_0_ready); end
    tick();
    tests++; if (ex_0_valid !== 1'b1 || ex_0_src2 !== 64'h1234) begin
      fails++; $display("FAIL raw_forward got v=%b %h exp v=1 1234", ex_0_valid, ex_0_src2); end
    idle_inputs();
    tick();
  endtask

  task automatic test_intra_pair();
    idle_inputs();
    id_0_valid = 1; id_0_rd = 9; id_0_rd_wen = 1;
    id_1_valid = 1; id_1_rs1 = 9;
    #1;
    tests++; if (id_0_ready !== 1'b1 || id_1_ready !== 1'b0) begin
      fails++; $display("FAIL intra_ready got %b%b exp 10", id_0_ready, id_1_ready); end
    tick();
    tests++; if (ex_0_valid !== 1'b1 || ex_1_valid !== 1'b0) begin
      fails++; $display("FAIL intra_valid got %b%b exp 10", ex_0_valid, ex_1_valid); end
    id_1_valid = 0; id_1_rs1 = 0;
    id_0_rd = 0; id_0_rd_wen = 0; id_0_rs1 = 9;
    #1;
    tests++; if (id_0_ready !== 1'b0) begin
      fails++; $display("FAIL intra_represent got %b exp 0", id_0_ready); end
    idle_inputs();
    wb_0_wen = 1; wb_0_waddr = 9;
    tick();
    // Independent pair issues together
    idle_inputs();
    id_0_valid = 1; id_0_rd = 10; id_0_rd_wen = 1; id_0_rs1 = 2;
    id_1_valid = 1; id_1_rd = 11; id_1_rd_wen = 1; id_1_rs1 = 1;
    rf_1_rdata1 = 64'hCAFE;
    tick();
    tests++; if (ex_1_valid !== 1'b1 || ex_1_rd !== 5'd11 || ex_1_src1 !== 64'hCAFE) begin
      fails++; $display("FAIL dual_issue got v=%b rd=%0d %h exp v=1 rd=11 cafe",
                        ex_1_valid, ex_1_rd, ex_1_src1); end
    idle_inputs();
    wb_0_wen = 1; wb_0_waddr = 10; wb_1_wen = 1; wb_1_waddr = 11;
    tick();
    idle_inputs();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    id_0_valid = 1; id_0_rs1 = 1; id_0_rs2 = 2; id_1_valid = 1; id_1_rs1 = 3; id_1_rs2 = 4;
    rf_0_rdata1 = 64'hA1; rf_0_rdata2 = 64'hA2; rf_1_rdata1 = 64'hB1; rf_1_rdata2 = 64'hB2;
    tick();
    ex_ready = 0;
    rf_0_rdata1 = 64'hC1; rf_0_rdata2 = 64'hC2; rf_1_rdata1 = 64'hD1; rf_1_rdata2 = 64'hD2;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (id_0_ready !== 1'b0 || id_1_ready !== 1'b0) begin
        fails++; $display("FAIL bp_ready cycle %0d got %b%b exp 00", i, id_0_ready,
                          id_1_ready); end
      tick();
      tests++; if (ex_0_valid !== 1'b1 || ex_1_valid !== 1'b1 || ex_0_src1 !== 64'hA1 ||
                   ex_0_src2 !== 64'hA2 || ex_1_src1 !== 64'hB1 || ex_1_src2 !== 64'hB2) begin
        fails++; $display("FAIL bp_hold cycle %0d got %b%b %h %h %h %h exp 11 a1 a2 b1 b2", i,
                          ex_0_valid, ex_1_valid, ex_0_src1, ex_0_src2, ex_1_src1,
                          ex_1_src2); end
    end
    ex_ready = 1;
    tick();
    tests++; if (ex_0_src1 !== 64'hC1 || ex_1_src2 !== 64'hD2 || ex_1_valid !== 1'b1) begin
      fails++; $display("FAIL bp_release got %h %h v1=%b exp c1 d2 v1=1", ex_0_src1,
                        ex_1_src2, ex_1_valid); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    idle_inputs();
    id_0_valid = 1; id_0_rd = 12; id_0_rd_wen = 1;
    tick();
    idle_inputs();
    ex_ready = 0; flush = 1;
    id_0_valid = 1; id_0_rs1 = 1;
    #1;
    tests++; if (id_0_ready !== 1'b0) begin
      fails++; $display("FAIL flush_ready got %b exp 0", id_0_ready); end
    tick();
    tests++; if (ex_0_valid !== 1'b0 || ex_1_valid !== 1'b0) begin
      fails++; $display("FAIL flush_valid got %b%b exp 00", ex_0_valid, ex_1_valid); end
    idle_inputs();
    id_0_valid = 1; id_0_rs1 = 12; rf_0_rdata1 = 64'h1212;
    #1;
    tests++; if (id_0_ready !== 1'b1) begin
      fails++; $display("FAIL flush_unbusy got %b exp 1", id_0_ready); end
    tick();
    tests++; if (ex_0_valid !== 1'b1 || ex_0_src1 !== 64'h1212) begin
      fails++; $display("FAIL flush_reissue got v=%b %h exp v=1 1212", ex_0_valid,
                        ex_0_src1); end
    idle_inputs();
    tick();
  endtask

  // Register r is busy this cycle unless it is x0 or a writeback lands on it now.
  function automatic bit seen_busy(logic [4:0] r);
    if (r == 0) return 0;
    if (wb_0_wen && wb_0_waddr == r) return 0;
    if (wb_1_wen && wb_1_waddr == r) return 0;
    return m_busy[r];
  endfunction

  function automatic logic [XLEN-1:0] ref_operand(logic [4:0] rs, logic [XLEN-1:0] rf);
    if (rs == 0) return '0;
    if (wb_1_wen && wb_1_waddr == rs) return wb_1_wdata;
    if (wb_0_wen && wb_0_waddr == rs) return wb_0_wdata;
    return rf;
  endfunction

  task automatic test_random();
    bit adv, hz0, hz1, r0, r1, a0, a1;
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    for (int r = 0; r < 32; r++) m_busy[r] = 0;
    for (int l = 0; l < 2; l++) begin
      m_v[l] = 0; m_s1[l] = 0; m_s2[l] = 0; m_rd[l] = 0; m_wen[l] = 0;
    end
    for (int cyc = 0; cyc < 600; cyc++) begin
      id_0_valid = ($urandom_range(0, 3) != 0);
      id_1_valid = id_0_valid && ($urandom_range(0, 1) == 1);
      id_0_rs1 = 5'($urandom_range(0, 7)); id_0_rs2 = 5'($urandom_range(0, 7));
      id_0_rd = 5'($urandom_range(0, 7));  id_0_rd_wen = ($urandom_range(0, 1) == 1);
      id_1_rs1 = 5'($urandom_range(0, 7)); id_1_rs2 = 5'($urandom_range(0, 7));
      id_1_rd = 5'($urandom_range(0, 7));  id_1_rd_wen = ($urandom_range(0, 1) == 1);
      rf_0_rdata1 = {$urandom, $urandom}; rf_0_rdata2 = {$urandom, $urandom};
      rf_1_rdata1 = {$urandom, $urandom}; rf_1_rdata2 = {$urandom, $urandom};
      wb_0_wen = ($urandom_range(0, 2) == 0); wb_0_waddr = 5'($urandom_range(0, 7));
      wb_1_wen = ($urandom_range(0, 2) == 0); wb_1_waddr = 5'($urandom_range(0, 7));
      wb_0_wdata = {$urandom, $urandom}; wb_1_wdata = {$urandom, $urandom};
      flush = ($urandom_range(0, 15) == 0);
      ex_ready = ($urandom_range(0, 3) != 0);
      #1;
      adv = !(m_v[0] || m_v[1]) || ex_ready;
      hz0 = seen_busy(id_0_rs1) || seen_busy(id_0_rs2) || (id_0_rd_wen && seen_busy(id_0_rd));
      hz1 = seen_busy(id_1_rs1) || seen_busy(id_1_rs2) || (id_1_rd_wen && seen_busy(id_1_rd)) ||
            (id_0_rd_wen && id_0_rd != 0 &&
             (id_1_rs1 == id_0_rd || id_1_rs2 == id_0_rd || id_1_rd == id_0_rd));
      r0 = adv && !hz0 && !flush;
      r1 = r0 && id_0_valid && !hz1;
      a0 = id_0_valid && r0;
      a1 = id_1_valid && r1;
      tests++; if (id_0_ready !== r0 || id_1_ready !== r1) begin
        fails++; $display("FAIL rand_ready cyc %0d got %b%b exp %b%b", cyc, id_0_ready,
                          id_1_ready, r0, r1); end
      // Model update for the coming edge
      if (wb_0_wen) m_busy[wb_0_waddr] = 0;
      if (wb_1_wen) m_busy[wb_1_waddr] = 0;
      if (flush) begin
        for (int l = 0; l < 2; l++) if (m_v[l] && m_wen[l]) m_busy[m_rd[l]] = 0;
        m_v[0] = 0; m_v[1] = 0;
      end else if (adv) begin
        if (a0) begin
          m_s1[0] = ref_operand(id_0_rs1, rf_0_rdata1);
          m_s2[0] = ref_operand(id_0_rs2, rf_0_rdata2);
          m_rd[0] = id_0_rd; m_wen[0] = id_0_rd_wen;
        end
        if (a1) begin
          m_s1[1] = ref_operand(id_1_rs1, rf_1_rdata1);
          m_s2[1] = ref_operand(id_1_rs2, rf_1_rdata2);
          m_rd[1] = id_1_rd; m_wen[1] = id_1_rd_wen;
        end
        m_v[0] = a0; m_v[1] = a1;
      end
      if (a0 && id_0_rd_wen) m_busy[id_0_rd] = 1;
      if (a1 && id_1_rd_wen) m_busy[id_1_rd] = 1;
      m_busy[0] = 0;
      tick();
      tests++; if (ex_0_valid !== m_v[0] || ex_1_valid !== m_v[1]) begin
        fails++; $display("FAIL rand_valid cyc %0d got %b%b exp %b%b", cyc, ex_0_valid,
                          ex_1_valid, m_v[0], m_v[1]); end
      tests++; if (ex_0_src1 !== m_s1[0] || ex_0_src2 !== m_s2[0] ||
                   ex_1_src1 !== m_s1[1] || ex_1_src2 !== m_s2[1]) begin
        fails++; $display("FAIL rand_src cyc %0d got %h %h %h %h exp %h %h %h %h", cyc,
                          ex_0_src1, ex_0_src2, ex_1_src1, ex_1_src2,
                          m_s1[0], m_s2[0], m_s1[1], m_s2[1]); end
      tests++; if (ex_0_rd !== m_rd[0] || ex_1_rd !== m_rd[1] ||
                   ex_0_rd_wen !== m_wen[0] || ex_1_rd_wen !== m_wen[1]) begin
        fails++; $display("FAIL rand_rd cyc %0d got %0d/%b %0d/%b exp %0d/%b %0d/%b", cyc,
                          ex_0_rd, ex_0_rd_wen, ex_1_rd, ex_1_rd_wen,
                          m_rd[0], m_wen[0], m_rd[1], m_wen[1]); end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_bypass();
    test_raw();
    test_intra_pair();
    test_backpressure();
    test_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
